// File: rtl/io_pkg.sv
// Shared types and constants for the CPU IO bus responder.
// Read-target enum, status bit positions and default device addresses.
package io_pkg;

  typedef enum logic [2:0] {
    TGT_NONE,
    TGT_ADDR,
    TGT_TX,
    TGT_RX,
    TGT_STAT
  } rd_tgt_e;

  // Status byte bit positions, bit 0 is the leftmost bit of a [0:7] byte
  localparam int ST_RX_NE  = 0;
  localparam int ST_TX_NF  = 1;
  localparam int ST_TX_OVF = 2;
  localparam int ST_RX_UNF = 3;
  localparam int ST_RX_OVF = 4;

  localparam logic [0:7] ADDR_TX_DEF   = 8'h01;
  localparam logic [0:7] ADDR_RX_DEF   = 8'h02;
  localparam logic [0:7] ADDR_STAT_DEF = 8'h03;

  function automatic rd_tgt_e decode_tgt(
    input logic       da,
    input logic [0:7] addr,
    input logic [0:7] a_tx,
    input logic [0:7] a_rx,
    input logic [0:7] a_st
  );
    rd_tgt_e t;
    t = TGT_NONE;
    if (!da)
      t = TGT_ADDR;
    else if (addr == a_tx)
      t = TGT_TX;
    else if (addr == a_rx)
      t = TGT_RX;
    else if (addr == a_st)
      t = TGT_STAT;
    return t;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Byte FIFO with power-of-two depth; push on full allowed if popping.
// Ports: clk, rst_n, push, pop, din -> head (0 when empty), full, empty.
module io_fifo
  import io_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [0:7] din,
  output logic [0:7] head,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [0:7]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/io_port_responder.sv
// Peripheral endpoint of the CPU IO bus: address/data ports, TX/RX FIFOs.
// Ports: CLK_*, IO_* strobes, bus_in/out/oe, tx_* sink and rx_* source.
module io_port_responder
  import io_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [0:7] ADDR_TX   = ADDR_TX_DEF,
  parameter logic [0:7] ADDR_RX   = ADDR_RX_DEF,
  parameter logic [0:7] ADDR_STAT = ADDR_STAT_DEF
) (
  input  logic       CLK_clk,
  input  logic       CLK_rstn,
  input  logic       IO_clks,
  input  logic       IO_clke,
  input  logic       IO_io,
  input  logic       IO_da,
  input  logic [0:7] bus_in,
  output logic [0:7] bus_out,
  output logic       bus_oe,
  output logic       tx_valid,
  output logic [0:7] tx_data,
  input  logic       tx_ready,
  input  logic       rx_valid,
  input  logic [0:7] rx_data,
  output logic       rx_ready
);

  logic       clks_q;
  logic       clke_q;
  // Set by reset; a strobe must be seen low before it can start an event
  logic       clks_blk;
  logic       clke_blk;

  logic       wr_ev;
  logic       rd_start;
  logic       rd_end;

  logic [0:7] addr_q;
  rd_tgt_e    rd_tgt;
  rd_tgt_e    live_tgt;
  rd_tgt_e    cur_tgt;

  logic       tx_ovf;
  logic       rx_unf;
  logic       rx_ovf;

  logic       wr_tx;
  logic       tx_push;
  logic       tx_pop;
  logic       tx_full;
  logic       tx_empty;
  logic [0:7] tx_head;
  logic       tx_ovf_set;

  logic       rd_rx_end;
  logic       rx_push;
  logic       rx_pop;
  logic       rx_full;
  logic       rx_empty;
  logic [0:7] rx_head;
  logic       rx_unf_set;
  logic       rx_ovf_set;
  logic       stat_clr;
  logic [0:7] stat;

  assign wr_ev    = IO_clks & !clks_q & !clks_blk;
  assign rd_start = IO_clke & !clke_q & !clke_blk;
  assign rd_end   = !IO_clke & clke_q;

  assign live_tgt = IO_io ? TGT_NONE
                  : decode_tgt(IO_da, addr_q,
                               ADDR_TX, ADDR_RX, ADDR_STAT);
  // First strobe cycle has no latched target yet
  assign cur_tgt  = rd_start ? live_tgt : rd_tgt;

  always_ff @(posedge CLK_clk or negedge CLK_rstn) begin
    if (!CLK_rstn) begin
      clks_q   <= 1'b0;
      clke_q   <= 1'b0;
      clks_blk <= 1'b1;
      clke_blk <= 1'b1;
      addr_q   <= '0;
      rd_tgt   <= TGT_NONE;
    end else begin
      clks_q   <= IO_clks;
      clke_q   <= IO_clke;
      clks_blk <= clks_blk & IO_clks;
      clke_blk <= clke_blk & IO_clke;
      if (wr_ev & IO_io & !IO_da)
        addr_q <= bus_in;
      if (rd_start)
        rd_tgt <= live_tgt;
      else if (rd_end)
        rd_tgt <= TGT_NONE;
    end
  end

  assign wr_tx      = wr_ev & IO_io & IO_da & (addr_q == ADDR_TX);
  assign tx_pop     = !tx_empty & tx_ready;
  assign tx_push    = wr_tx & (!tx_full | tx_pop);
  assign tx_ovf_set = wr_tx & tx_full & !tx_pop;

  assign rd_rx_end  = rd_end & (rd_tgt == TGT_RX);
  assign rx_pop     = rd_rx_end & !rx_empty;
  assign rx_unf_set = rd_rx_end & rx_empty;
  assign rx_ready   = !rx_full | rx_pop;
  assign rx_push    = rx_valid & rx_ready;
  assign rx_ovf_set = rx_valid & !rx_ready;
  assign stat_clr   = rd_end & (rd_tgt == TGT_STAT);

  // A flag raised in the clearing cycle survives the clear
  always_ff @(posedge CLK_clk or negedge CLK_rstn) begin
    if (!CLK_rstn) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      tx_ovf <= (tx_ovf & !stat_clr) | tx_ovf_set;
      rx_unf <= (rx_unf & !stat_clr) | rx_unf_set;
      rx_ovf <= (rx_ovf & !stat_clr) | rx_ovf_set;
    end
  end

  io_fifo #(.DEPTH(DEPTH)) u_tx (
    .clk   (CLK_clk),
    .rst_n (CLK_rstn),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (bus_in),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  io_fifo #(.DEPTH(DEPTH)) u_rx (
    .clk   (CLK_clk),
    .rst_n (CLK_rstn),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_head;

  always_comb begin
    stat            = '0;
    stat[ST_RX_NE]  = !rx_empty;
    stat[ST_TX_NF]  = !tx_full;
    stat[ST_TX_OVF] = tx_ovf;
    stat[ST_RX_UNF] = rx_unf;
    stat[ST_RX_OVF] = rx_ovf;
  end

  assign bus_oe = IO_clke & !IO_io & !clke_blk;

  always_comb begin
    bus_out = '0;
    unique case (cur_tgt)
      TGT_ADDR: bus_out = addr_q;
      TGT_RX:   bus_out = rx_head;
      TGT_STAT: bus_out = stat;
      default:  bus_out = '0;
    endcase
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Self-checking bench for io_port_responder.
// Vector table, hand sequences for corner cases, random ops vs model.
module tb_io_port_responder;

  logic       clk;
  logic       rstn;
  logic       clks;
  logic       clke;
  logic       io;
  logic       da;
  logic [0:7] bus_in;
  logic [0:7] bus_out;
  logic       bus_oe;
  logic       tx_valid;
  logic [0:7] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [0:7] rx_data;
  logic       rx_ready;

  int n_chk = 0;
  int n_fail = 0;

  io_port_responder dut (
    .CLK_clk  (clk),
    .CLK_rstn (rstn),
    .IO_clks  (clks),
    .IO_clke  (clke),
    .IO_io    (io),
    .IO_da    (da),
    .bus_in   (bus_in),
    .bus_out  (bus_out),
    .bus_oe   (bus_oe),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  typedef enum {T_WA, T_WD, T_WX, T_RD, T_SRC, T_SNK, T_TXV} op_e;
  typedef struct {
    op_e         op;
    logic        da;
    logic [7:0]  val;
    int          len;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(op_e op, logic d, logic [7:0] v,
                              int len, logic [15:0] e);
    tbl.push_back('{op: op, da: d, val: v, len: len, exp: e});
  endfunction

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic io_v, input logic da_v,
                          input logic [0:7] v, input int len);
    io = io_v;
    da = da_v;
    bus_in = v;
    clks = 1'b1;
    repeat (len) step();
    clks = 1'b0;
    io = 1'b0;
    da = 1'b0;
    step();
  endtask

  // got = {stable, oe during strobe, oe after drop, first byte}
  task automatic do_rd(input logic da_v, input int len,
                       input logic end_push, input logic [0:7] pd,
                       output logic [15:0] got, output logic rdy);
    logic [0:7] v0;
    logic [0:7] v1;
    logic oe0;
    logic oe1;
    logic oe2;
    io = 1'b0;
    da = da_v;
    clke = 1'b1;
    #1;
    v0 = bus_out;
    oe0 = bus_oe;
    repeat (len) step();
    v1 = bus_out;
    oe1 = bus_oe;
    clke = 1'b0;
    if (end_push) begin
      rx_valid = 1'b1;
      rx_data = pd;
    end
    #1;
    oe2 = bus_oe;
    rdy = rx_ready;
    step();
    rx_valid = 1'b0;
    da = 1'b0;
    got = {5'b0, (v0 == v1), oe0 & oe1, oe2, v0};
  endtask

  task automatic do_src(input logic [0:7] d, output logic rdy);
    rx_valid = 1'b1;
    rx_data = d;
    #1;
    rdy = rx_ready;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic do_snk(output logic [15:0] got);
    got = {7'b0, tx_valid, tx_data};
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
  endtask

  // Reference model state for the random phase
  byte unsigned txq[$];
  byte unsigned rxq[$];
  logic [7:0] m_addr;
  logic m_txovf, m_rxunf, m_rxovf;

  function automatic logic [7:0] m_stat();
    logic [0:7] s;
    s = '0;
    s[0] = (rxq.size() != 0);
    s[1] = (txq.size() < 4);
    s[2] = m_txovf;
    s[3] = m_rxunf;
    s[4] = m_rxovf;
    return s;
  endfunction

  task automatic pulse_reset();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    txq.delete();
    rxq.delete();
    m_addr = 8'h00;
    m_txovf = 1'b0;
    m_rxunf = 1'b0;
    m_rxovf = 1'b0;
  endtask

  logic [15:0] got;
  logic rdy;
  int acc;

  initial begin
    logic [7:0] addrs [5];
    addrs = '{8'h01, 8'h02, 8'h03, 8'h77, 8'h00};
    rstn = 1'b0;
    clks = 1'b0;
    clke = 1'b0;
    io = 1'b0;
    da = 1'b0;
    bus_in = '0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data = '0;

    add(T_WA, 0, 8'h01, 1, 0);
    add(T_WD, 0, 8'hA5, 1, 0);
    add(T_TXV, 0, 0, 0, 16'h01A5);
    add(T_SNK, 0, 0, 0, 16'h01A5);
    add(T_TXV, 0, 0, 0, 16'h0000);
    for (int i = 0; i < 5; i++)
      add(T_WD, 0, 8'h10 + 8'(i), 1, 0);
    add(T_WA, 0, 8'h03, 1, 0);
    add(T_RD, 1, 0, 1, 16'h0620);
    add(T_RD, 1, 0, 2, 16'h0600);
    for (int i = 0; i < 4; i++)
      add(T_SNK, 0, 0, 0, 16'h0110 + 16'(i));
    add(T_TXV, 0, 0, 0, 16'h0000);
    add(T_SRC, 0, 8'h3C, 0, 16'h0001);
    add(T_SRC, 0, 8'hC3, 0, 16'h0001);
    add(T_WA, 0, 8'h02, 1, 0);
    add(T_RD, 1, 0, 3, 16'h063C);
    add(T_RD, 1, 0, 3, 16'h06C3);
    add(T_RD, 1, 0, 3, 16'h0600);
    add(T_WA, 0, 8'h03, 1, 0);
    add(T_RD, 1, 0, 1, 16'h0650);
    add(T_RD, 1, 0, 1, 16'h0640);
    add(T_WA, 0, 8'h77, 1, 0);
    add(T_RD, 0, 0, 2, 16'h0677);
    add(T_WD, 0, 8'h5A, 1, 0);
    add(T_TXV, 0, 0, 0, 16'h0000);
    add(T_WX, 0, 8'h12, 1, 0);
    add(T_RD, 0, 0, 1, 16'h0677);
    add(T_WA, 0, 8'h03, 1, 0);
    add(T_RD, 1, 0, 1, 16'h0640);
    add(T_WA, 0, 8'h01, 1, 0);
    add(T_WD, 0, 8'h99, 4, 0);
    add(T_TXV, 0, 0, 0, 16'h0199);
    add(T_SNK, 0, 0, 0, 16'h0199);
    add(T_TXV, 0, 0, 0, 16'h0000);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in", {5'b0, bus_oe, tx_valid, rx_ready, bus_out}, 16'h0100);
    chk("rst_txd", {8'h0, tx_data}, 16'h0000);
    rstn = 1'b1;
    step();
    chk("post_rst", {5'b0, bus_oe, tx_valid, rx_ready, bus_out}, 16'h0100);

    foreach (tbl[i]) begin
      unique case (tbl[i].op)
        T_WA:  do_write(1'b1, 1'b0, tbl[i].val, tbl[i].len);
        T_WD:  do_write(1'b1, 1'b1, tbl[i].val, tbl[i].len);
        T_WX:  do_write(1'b0, 1'b0, tbl[i].val, tbl[i].len);
        T_RD: begin
          do_rd(tbl[i].da, tbl[i].len, 1'b0, 8'h00, got, rdy);
          chk($sformatf("tbl%0d_rd", i), got, tbl[i].exp);
        end
        T_SRC: begin
          do_src(tbl[i].val, rdy);
          chk($sformatf("tbl%0d_src", i), {15'b0, rdy}, tbl[i].exp);
        end
        T_SNK: begin
          do_snk(got);
          chk($sformatf("tbl%0d_snk", i), got, tbl[i].exp);
        end
        default:
          chk($sformatf("tbl%0d_txv", i),
              {7'b0, tx_valid, tx_data}, tbl[i].exp);
      endcase
    end

    // RX overflow, pop+push on full, flag set during clear
    acc = 0;
    rx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rx_data = 8'h40 + 8'(i);
      #1;
      if (rx_ready)
        acc++;
      step();
    end
    rx_valid = 1'b0;
    chk("ovf_acc", 16'(acc), 16'd4);
    chk("ovf_rdy", {15'b0, rx_ready}, 16'h0000);
    do_write(1'b1, 1'b0, 8'h02, 1);
    do_rd(1'b1, 2, 1'b1, 8'h50, got, rdy);
    chk("pp_rd", got, 16'h0640);
    chk("pp_rdy", {15'b0, rdy}, 16'h0001);
    chk("pp_full", {15'b0, rx_ready}, 16'h0000);
    do_write(1'b1, 1'b0, 8'h03, 1);
    do_rd(1'b1, 1, 1'b1, 8'h51, got, rdy);
    chk("st_ovf", got, 16'h06C8);
    chk("st_rdy", {15'b0, rdy}, 16'h0000);
    do_rd(1'b1, 1, 1'b0, 8'h00, got, rdy);
    chk("st_win", got, 16'h06C8);
    do_rd(1'b1, 1, 1'b0, 8'h00, got, rdy);
    chk("st_clr", got, 16'h06C0);
    do_write(1'b1, 1'b0, 8'h02, 1);
    for (int i = 0; i < 4; i++) begin
      do_rd(1'b1, 1, 1'b0, 8'h00, got, rdy);
      chk($sformatf("drain%0d", i), got,
          (i == 3) ? 16'h0650 : 16'h0641 + 16'(i));
    end
    do_write(1'b1, 1'b0, 8'h03, 1);
    do_rd(1'b1, 1, 1'b0, 8'h00, got, rdy);
    chk("drain_st", got, 16'h0640);

    // Reset in the middle of an RX read
    do_write(1'b1, 1'b0, 8'h01, 1);
    do_write(1'b1, 1'b1, 8'h66, 1);
    do_src(8'hAA, rdy);
    do_src(8'hBB, rdy);
    do_write(1'b1, 1'b0, 8'h02, 1);
    io = 1'b0;
    da = 1'b1;
    clke = 1'b1;
    step();
    chk("mid_rd", {7'b0, bus_oe, bus_out}, 16'h01AA);
    rstn = 1'b0;
    #1;
    chk("mid_rst", {5'b0, bus_oe, tx_valid, rx_ready, bus_out}, 16'h0100);
    step();
    step();
    rstn = 1'b1;
    step();
    step();
    chk("held_oe", {15'b0, bus_oe}, 16'h0000);
    clke = 1'b0;
    da = 1'b0;
    step();
    step();
    do_write(1'b1, 1'b0, 8'h03, 1);
    do_rd(1'b1, 1, 1'b0, 8'h00, got, rdy);
    chk("rst_st", got, 16'h0640);

    // Write strobe held across reset release is no event
    io = 1'b1;
    da = 1'b0;
    bus_in = 8'h02;
    clks = 1'b1;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    step();
    clks = 1'b0;
    io = 1'b0;
    step();
    do_rd(1'b0, 1, 1'b0, 8'h00, got, rdy);
    chk("held_wr", got, 16'h0600);

    // Random operations against the queue model
    pulse_reset();
    for (int n = 0; n < 300; n++) begin
      int op;
      logic [7:0] v;
      logic [7:0] e;
      logic d;
      op = $urandom_range(0, 9);
      v = 8'($urandom);
      if (op <= 1) begin
        v = addrs[$urandom_range(0, 4)];
        do_write(1'b1, 1'b0, v, $urandom_range(1, 3));
        m_addr = v;
      end else if (op <= 4) begin
        do_write(1'b1, 1'b1, v, $urandom_range(1, 3));
        if (m_addr == 8'h01) begin
          if (txq.size() < 4)
            txq.push_back(v);
          else
            m_txovf = 1'b1;
        end
      end else if (op <= 6) begin
        d = 1'($urandom);
        if (!d)
          e = m_addr;
        else if (m_addr == 8'h02)
          e = (rxq.size() != 0) ? rxq[0] : 8'h00;
        else if (m_addr == 8'h03)
          e = m_stat();
        else
          e = 8'h00;
        do_rd(d, $urandom_range(1, 3), 1'b0, 8'h00, got, rdy);
        chk($sformatf("rnd%0d_rd", n), got, 16'h0600 | 16'(e));
        if (d && m_addr == 8'h02) begin
          if (rxq.size() != 0)
            void'(rxq.pop_front());
          else
            m_rxunf = 1'b1;
        end
        if (d && m_addr == 8'h03) begin
          m_txovf = 1'b0;
          m_rxunf = 1'b0;
          m_rxovf = 1'b0;
        end
      end else if (op == 7) begin
        do_src(v, rdy);
        chk($sformatf("rnd%0d_src", n), {15'b0, rdy},
            {15'b0, rxq.size() < 4});
        if (rxq.size() < 4)
          rxq.push_back(v);
        else
          m_rxovf = 1'b1;
      end else begin
        do_snk(got);
        e = (txq.size() != 0) ? txq[0] : 8'h00;
        chk($sformatf("rnd%0d_snk", n), got,
            {7'b0, txq.size() != 0, e});
        if (txq.size() != 0)
          void'(txq.pop_front());
      end
      e = (txq.size() != 0) ? txq[0] : 8'h00;
      chk($sformatf("rnd%0d_if", n),
          {6'b0, rx_ready, tx_valid, tx_data},
          {6'b0, rxq.size() < 4, txq.size() != 0, e});
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
